pipeline_trace_monitor: RTL and testbench
=========================================

# pipeline_trace_monitor

Synthesizable execution-trace capture block for the CPU. It runs alongside the core and samples the PC and register-file writeback every cycle. Samples go into a parametrised FIFO with a valid/ready drain port. Capture stops on a programmable cycle limit or a PC breakpoint, replacing the fixed 30-cycle print-every-cycle bench dump with a reusable trace source for simulation and FPGA bring-up.

## Interface
Parameters:
- XLEN, 32, PC and data width
- REG_ADDR_W, 5, register address width
- DEPTH, 16, FIFO entries; power of two, ≥2
- CYCLE_W, 16, cycle counter and drop counter width

Ports:
- clk_i  in  1  clock; all logic on posedge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  arms capture (level, sampled in IDLE)
- mode_i  in  1  0 = record every cycle; 1 = record only cycles with rf_we_i=1
- max_cycles_i  in  CYCLE_W  cycle limit; 0 = unlimited
- bp_en_i  in  1  PC breakpoint enable
- bp_pc_i  in  XLEN  breakpoint PC
- pc_i  in  XLEN  current PC from the PC register
- rf_we_i  in  1  register-file write enable
- rf_waddr_i  in  REG_ADDR_W  write address
- rf_wdata_i  in  XLEN  write data
- rec_valid_o  out  1  FIFO head valid
- rec_ready_i  in  1  consumer accepts head
- rec_cycle_o  out  CYCLE_W  cycle index of head record
- rec_pc_o  out  XLEN  PC of head record
- rec_we_o / rec_waddr_o / rec_wdata_o  out  1 / REG_ADDR_W / XLEN  writeback fields of head record
- count_o  out  log2(DEPTH)+1  current FIFO occupancy
- running_o  out  1  state == RUN
- done_o  out  1  state == DONE
- overflow_o  out  1  sticky: a record was dropped
- drop_cnt_o  out  CYCLE_W  dropped-record count, saturating

## Operation
- Reset:
  - state = IDLE.
  - FIFO empty.
  - cycle counter, drop_cnt_o, overflow_o, count_o all 0.
  - rec_valid_o, running_o, done_o all 0.
  - rec_* data outputs are 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on the first posedge with start_i=1.
  - RUN -> DONE on a terminal cycle.
  - DONE holds until rst_i. start_i is ignored in DONE.
- RUN capture:
  - Each RUN cycle is indexed n = 0, 1, 2, … by the cycle counter. The counter increments once per RUN cycle and saturates at all-ones.
  - Push condition: mode_i==0, or rf_we_i==1.
  - A pushed record holds {n, pc_i, rf_we_i, rf_waddr_i, rf_wdata_i}, all sampled at that posedge.
  - Writes to address 0 are recorded as presented; there is no filtering.
- Terminal cycle: either condition below ends the run.
  - Cycle limit: max_cycles_i≠0 and n == max_cycles_i−1.
  - Breakpoint: bp_en_i=1 and pc_i == bp_pc_i.
  - The terminal cycle itself is still captured, subject to the mode rule. No pushes occur after it.
- FIFO:
  - Pop when rec_valid_o && rec_ready_i.
  - Push while full without a simultaneous pop: the new record is dropped, overflow_o is set, and drop_cnt_o increments (saturating).
  - Push and pop in the same cycle while full: both succeed and occupancy is unchanged.
  - Pop when empty: no effect.
  - Pointers wrap modulo DEPTH. Full/empty is decided by the extra MSB on the pointers.
- Drain: the FIFO remains drainable in DONE and in IDLE.
- Reset mid-operation: rst_i at any time returns the block to the reset state. Pending records are discarded.

## Timing
- Capture: a push sampled at edge k is visible at the head at edge k+1, so rec_valid_o rises one cycle after the push into an empty FIFO.
- Head outputs: rec_* are registered/stable while rec_valid_o=1 and rec_ready_i=0.
- count_o: reflects the pushes and pops of the previous edge.
- running_o: rises one cycle after start_i is sampled in IDLE.
- done_o: rises one cycle after the terminal-cycle edge. It is asserted in the same cycle that the terminal record becomes visible if the FIFO was empty.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Cycle limit, full record: mode_i=0, max_cycles_i=30, DEPTH=16, rec_ready_i=1, pc_i advancing by 4 from 0 -> 30 records with cycles 0..29 and PCs 0..116; done_o=1 after cycle 29; drop_cnt_o=0.
- Writeback-only: mode_i=1, max_cycles_i=10, rf_we_i=1 on cycles 2 and 5 (r8=5, r9=7) -> exactly 2 records {2,r8,5}, {5,r9,7}.
- Breakpoint: bp_en_i=1, bp_pc_i=0x20, max_cycles_i=0, PC +4 per cycle -> final record at cycle 8 with PC 0x20; done_o=1; no pushes afterwards.
- Overflow: mode_i=0, rec_ready_i=0, max_cycles_i=20, DEPTH=16 -> count_o=16, drop_cnt_o=4, overflow_o=1; draining yields cycles 0..15 in order.
- Full with simultaneous push/pop: FIFO full, rec_ready_i=1 for one RUN cycle -> count_o stays 16, no drop, new tail is the record for that cycle.
- Reset mid-run: assert rst_i at cycle 5 with 3 records queued -> next cycle shows state IDLE, count_o=0, rec_valid_o=0, overflow_o=0.

Source files
------------

// File: rtl/pipeline_trace_monitor.sv
// Execution-trace capture: samples PC and register-file writeback while armed,
// queues records in a FIFO with a valid/ready drain, and stops on a cycle limit or PC breakpoint.
module pipeline_trace_monitor #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int DEPTH      = 16,
   parameter int CYCLE_W    = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic                      mode_i,
   input  logic [CYCLE_W-1:0]        max_cycles_i,
   input  logic                      bp_en_i,
   input  logic [XLEN-1:0]           bp_pc_i,
   input  logic [XLEN-1:0]           pc_i,
   input  logic                      rf_we_i,
   input  logic [REG_ADDR_W-1:0]     rf_waddr_i,
   input  logic [XLEN-1:0]           rf_wdata_i,
   output logic                      rec_valid_o,
   input  logic                      rec_ready_i,
   output logic [CYCLE_W-1:0]        rec_cycle_o,
   output logic [XLEN-1:0]           rec_pc_o,
   output logic                      rec_we_o,
   output logic [REG_ADDR_W-1:0]     rec_waddr_o,
   output logic [XLEN-1:0]           rec_wdata_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic                      running_o,
   output logic                      done_o,
   output logic                      overflow_o,
   output logic [CYCLE_W-1:0]        drop_cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int RW = CYCLE_W + XLEN + 1 + REG_ADDR_W + XLEN;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state;
   state_t              nextState;
   logic [CYCLE_W-1:0]  cycleCnt;
   logic [AW:0]         wrPtr;
   logic [AW:0]         rdPtr;
   logic [RW-1:0]       mem [DEPTH];
   logic [RW-1:0]       newRec;
   logic [RW-1:0]       headRec;

   logic isRun;
   logic limitHit;
   logic bpHit;
   logic terminal;
   logic wantPush;
   logic fifoEmpty;
   logic fifoFull;
   logic doPush;
   logic doPop;
   logic dropRec;

   assign isRun     = (state == RUN);
   assign limitHit  = (max_cycles_i != '0) && (cycleCnt == max_cycles_i - CYCLE_W'(1));
   assign bpHit     = bp_en_i && (pc_i == bp_pc_i);
   assign terminal  = isRun && (limitHit || bpHit);
   assign wantPush  = isRun && (!mode_i || rf_we_i);

   // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
   assign fifoEmpty = (wrPtr == rdPtr);
   assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign doPop     = !fifoEmpty && rec_ready_i;
   assign doPush    = wantPush && (!fifoFull || doPop);
   assign dropRec   = wantPush && fifoFull && !doPop;

   assign newRec    = {cycleCnt, pc_i, rf_we_i, rf_waddr_i, rf_wdata_i};
   assign headRec   = fifoEmpty ? '0 : mem[rdPtr[AW-1:0]];

   assign {rec_cycle_o, rec_pc_o, rec_we_o, rec_waddr_o, rec_wdata_o} = headRec;
   assign rec_valid_o = !fifoEmpty;
   assign count_o     = wrPtr - rdPtr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (start_i)  nextState = RUN;
         RUN:     if (terminal) nextState = DONE;
         DONE:    nextState = DONE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      running_o = 1'b0;
      done_o    = 1'b0;
      unique case (state)
         RUN:     running_o = 1'b1;
         DONE:    done_o    = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cycleCnt   <= '0;
         wrPtr      <= '0;
         rdPtr      <= '0;
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
      end else begin
         if (isRun && (cycleCnt != '1)) begin
            cycleCnt <= cycleCnt + CYCLE_W'(1);
         end
         if (doPush) begin
            wrPtr <= wrPtr + (AW+1)'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + (AW+1)'(1);
         end
         if (dropRec) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != '1) begin
               drop_cnt_o <= drop_cnt_o + CYCLE_W'(1);
            end
         end
      end
   end

   // Storage is left unreset; the empty flag masks stale entries at the head.
   always_ff @(posedge clk_i) begin
      if (doPush) begin
         mem[wrPtr[AW-1:0]] <= newRec;
      end
   end

endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// Directed bench for pipeline_trace_monitor: a cycle-by-cycle vector table plus
// hand-written runs for cycle limit, writeback-only, breakpoint, overflow and reset.
module tb_pipeline_trace_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mode;
   logic [15:0] maxCycles;
   logic        bpEn;
   logic [31:0] bpPc;
   logic [31:0] pc;
   logic        rfWe;
   logic [4:0]  rfWaddr;
   logic [31:0] rfWdata;
   logic        recValid;
   logic        recReady;
   logic [15:0] recCycle;
   logic [31:0] recPc;
   logic        recWe;
   logic [4:0]  recWaddr;
   logic [31:0] recWdata;
   logic [4:0]  count;
   logic        running;
   logic        done;
   logic        overflow;
   logic [15:0] dropCnt;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      logic [15:0] cycle;
      logic [31:0] pc;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } rec_t;

   rec_t captured [$];

   typedef struct {
      logic        start;
      logic        mode;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic        ready;
      logic        expValid;
      logic [4:0]  expCount;
      logic        expRunning;
      logic        expDone;
      logic [15:0] expCycle;
      logic [31:0] expPc;
      logic        expWe;
      logic [4:0]  expWaddr;
      logic [31:0] expWdata;
   } vec_t;

   vec_t vecs [8];

   pipeline_trace_monitor #(
      .XLEN(32), .REG_ADDR_W(5), .DEPTH(16), .CYCLE_W(16)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
      .max_cycles_i(maxCycles), .bp_en_i(bpEn), .bp_pc_i(bpPc), .pc_i(pc),
      .rf_we_i(rfWe), .rf_waddr_i(rfWaddr), .rf_wdata_i(rfWdata),
      .rec_valid_o(recValid), .rec_ready_i(recReady), .rec_cycle_o(recCycle),
      .rec_pc_o(recPc), .rec_we_o(recWe), .rec_waddr_o(recWaddr), .rec_wdata_o(recWdata),
      .count_o(count), .running_o(running), .done_o(done),
      .overflow_o(overflow), .drop_cnt_o(dropCnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Record the head if it is being accepted this edge, then advance one cycle.
   task automatic tick();
      if (recValid && recReady) begin
         captured.push_back('{recCycle, recPc, recWe, recWaddr, recWdata});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      rst = 1'b1; start = 1'b0; mode = 1'b0; maxCycles = '0; bpEn = 1'b0; bpPc = '0;
      pc = '0; rfWe = 1'b0; rfWaddr = '0; rfWdata = '0; recReady = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      captured.delete();
   endtask

   task automatic applyStimulus(input vec_t v);
      start    = v.start;
      mode     = v.mode;
      rfWe     = v.we;
      rfWaddr  = v.waddr;
      rfWdata  = v.wdata;
      pc       = v.pc;
      recReady = v.ready;
   endtask

   task automatic drain(input string name);
      recReady = 1'b1;
      for (int k = 0; k < 24 && recValid; k++) tick();
      checkOutput({name, " drained"}, recValid, 1'b0);
   endtask

   initial begin
      int errs;

      // start mode we waddr wdata pc ready | valid count run done cycle pc we waddr wdata
      vecs[0] = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,  32'h100, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 16'd0, 32'h0,   1'b0, 5'd0, 32'h0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 5'd3, 32'hAA, 32'h100, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 16'd0, 32'h100, 1'b1, 5'd3, 32'hAA};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 5'd7, 32'h11, 32'h104, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 16'd0, 32'h100, 1'b1, 5'd3, 32'hAA};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 5'd0, 32'h55, 32'h108, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 16'd0, 32'h100, 1'b1, 5'd3, 32'hAA};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,  32'h0,   1'b1, 1'b1, 5'd2, 1'b0, 1'b1, 16'd1, 32'h104, 1'b0, 5'd7, 32'h11};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  32'h0,   1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 16'd2, 32'h108, 1'b1, 5'd0, 32'h55};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  32'h0,   1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 16'd0, 32'h0,   1'b0, 5'd0, 32'h0};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  32'h0,   1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 16'd0, 32'h0,   1'b0, 5'd0, 32'h0};

      resetDut();
      checkOutput("reset valid", recValid, 1'b0);
      checkOutput("reset count", count, 5'd0);
      checkOutput("reset running", running, 1'b0);
      checkOutput("reset done", done, 1'b0);
      checkOutput("reset overflow", overflow, 1'b0);
      checkOutput("reset dropCnt", dropCnt, 16'd0);
      checkOutput("reset recPc", recPc, 32'h0);

      maxCycles = 16'd3;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput($sformatf("vec%0d valid", i), recValid, vecs[i].expValid);
         checkOutput($sformatf("vec%0d count", i), count, vecs[i].expCount);
         checkOutput($sformatf("vec%0d running", i), running, vecs[i].expRunning);
         checkOutput($sformatf("vec%0d done", i), done, vecs[i].expDone);
         if (vecs[i].expValid) begin
            checkOutput($sformatf("vec%0d cycle", i), recCycle, vecs[i].expCycle);
            checkOutput($sformatf("vec%0d pc", i), recPc, vecs[i].expPc);
            checkOutput($sformatf("vec%0d we", i), recWe, vecs[i].expWe);
            checkOutput($sformatf("vec%0d waddr", i), recWaddr, vecs[i].expWaddr);
            checkOutput($sformatf("vec%0d wdata", i), recWdata, vecs[i].expWdata);
         end
      end

      // Cycle limit of 30, every cycle recorded, consumer always ready.
      resetDut();
      maxCycles = 16'd30; recReady = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 30; n++) begin
         pc = 32'(4 * n);
         tick();
      end
      checkOutput("limit done", done, 1'b1);
      drain("limit");
      checkOutput("limit records", captured.size(), 30);
      errs = 0;
      foreach (captured[i]) begin
         if (captured[i].cycle != 16'(i) || captured[i].pc != 32'(4 * i)) errs++;
      end
      checkOutput("limit order errors", errs, 0);
      checkOutput("limit dropCnt", dropCnt, 16'd0);

      // Writeback-only capture.
      resetDut();
      mode = 1'b1; maxCycles = 16'd10; recReady = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 10; n++) begin
         pc      = 32'(4 * n);
         rfWe    = (n == 2 || n == 5);
         rfWaddr = (n == 2) ? 5'd8 : 5'd9;
         rfWdata = (n == 2) ? 32'd5 : 32'd7;
         tick();
      end
      rfWe = 1'b0;
      checkOutput("wb done", done, 1'b1);
      drain("wb");
      checkOutput("wb records", captured.size(), 2);
      if (captured.size() == 2) begin
         checkOutput("wb rec0", {captured[0].cycle, captured[0].waddr, captured[0].wdata}, {16'd2, 5'd8, 32'd5});
         checkOutput("wb rec1", {captured[1].cycle, captured[1].waddr, captured[1].wdata}, {16'd5, 5'd9, 32'd7});
      end

      // PC breakpoint at 0x20 with no cycle limit.
      resetDut();
      bpEn = 1'b1; bpPc = 32'h20; recReady = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 9; n++) begin
         pc = 32'(4 * n);
         tick();
      end
      checkOutput("bp done", done, 1'b1);
      for (int n = 9; n < 12; n++) begin
         pc = 32'(4 * n);
         tick();
      end
      drain("bp");
      checkOutput("bp records", captured.size(), 9);
      if (captured.size() > 0) begin
         checkOutput("bp last cycle", captured[$].cycle, 16'd8);
         checkOutput("bp last pc", captured[$].pc, 32'h20);
      end

      // Overflow with a stalled consumer.
      resetDut();
      maxCycles = 16'd20; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 20; n++) begin
         pc = 32'(4 * n);
         tick();
      end
      checkOutput("ovf count", count, 5'd16);
      checkOutput("ovf dropCnt", dropCnt, 16'd4);
      checkOutput("ovf flag", overflow, 1'b1);
      checkOutput("ovf done", done, 1'b1);
      drain("ovf");
      checkOutput("ovf records", captured.size(), 16);
      errs = 0;
      foreach (captured[i]) if (captured[i].cycle != 16'(i)) errs++;
      checkOutput("ovf order errors", errs, 0);
      checkOutput("ovf flag sticky", overflow, 1'b1);

      // Full FIFO with a simultaneous push and pop.
      resetDut();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 16; n++) begin
         pc = 32'(4 * n);
         tick();
      end
      checkOutput("full count", count, 5'd16);
      pc = 32'(4 * 16); recReady = 1'b1;
      tick();
      recReady = 1'b0;
      checkOutput("full pushpop count", count, 5'd16);
      checkOutput("full pushpop dropCnt", dropCnt, 16'd0);
      checkOutput("full pushpop overflow", overflow, 1'b0);
      pc = 32'(4 * 17); mode = 1'b1; bpEn = 1'b1; bpPc = 32'(4 * 17);
      tick();
      checkOutput("full done", done, 1'b1);
      checkOutput("full count after", count, 5'd16);
      drain("full");
      checkOutput("full records", captured.size(), 17);
      if (captured.size() > 0) checkOutput("full tail cycle", captured[$].cycle, 16'd16);

      // Reset in the middle of a run with records queued.
      resetDut();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 5; n++) begin
         mode = (n >= 3);
         pc   = 32'(4 * n);
         tick();
      end
      checkOutput("midrst queued", count, 5'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midrst running", running, 1'b0);
      checkOutput("midrst done", done, 1'b0);
      checkOutput("midrst count", count, 5'd0);
      checkOutput("midrst valid", recValid, 1'b0);
      checkOutput("midrst overflow", overflow, 1'b0);
      checkOutput("midrst recPc", recPc, 32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
